kfps2kb_receive_data: RTL and testbench
=======================================

KFPS2KB_RECEIVE_DATA -- requirements
Module: kfps2kb_receive_data

Interface
REQ-001 Parameter device_in_timeout, default 16'd4000: maximum clock cycles allowed between consecutive device_clock falling edges inside a frame.
REQ-002 The block SHALL have one clock and asynchronous active-low reset; all flops run on the falling edge of clock.
REQ-003 clock  in  1  system clock.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 device_clock  in  1  raw PS/2 clock line, asynchronous to clock.
REQ-006 device_data  in  1  raw PS/2 data line, asynchronous to clock.
REQ-007 receive_inhibit  in  1  high while the host transmitter owns the bus; aborts/blocks reception.
REQ-008 clear_request  in  1  level; consumer acknowledges byte and clears sticky flags.
REQ-009 receive_data  out  8  last accepted byte.
REQ-010 receive_flag  out  1  byte available, held until cleared.
REQ-011 parity_error  out  1  last accepted frame failed odd parity.
REQ-012 framing_error  out  1  last accepted frame had stop bit 0.
REQ-013 overrun_error  out  1  sticky; frame completed while receive_flag was set.
REQ-014 timeout_error  out  1  sticky; frame aborted by inter-edge timeout.
REQ-015 receiving_flag  out  1  high whenever state is not IDLE.

Function
REQ-016 device_clock and device_data SHALL each pass a 2-flop synchronizer; device_clock_edge = synced previous 1 and synced current 0.
REQ-017 Bits SHALL be sampled from synced device_data in the device_clock_edge cycle, LSB first: start, D0..D7, parity, stop.
REQ-018 States: IDLE, DATA, PARITY, STOP, COMPLETE.
REQ-019 IDLE: on edge with sampled 0 -> DATA, bit counter cleared; sampled 1 -> stay IDLE, no error.
REQ-020 DATA: each edge shifts bit into 8-bit shift register at bit 7 (right shift); after the 8th edge -> PARITY.
REQ-021 PARITY: edge captures parity bit -> STOP.
REQ-022 STOP: edge captures stop bit -> COMPLETE.
REQ-023 COMPLETE: lasts exactly one cycle, then -> IDLE; receive_flag and outputs update on the edge ending COMPLETE (2 clocks after the stop-bit device_clock_edge cycle).
REQ-024 Parity check: parity_error = ~(XOR of D0..D7 XOR parity bit), i.e. ones count over 9 bits must be odd.
REQ-025 In COMPLETE with receive_flag=0 or clear_request=1: load receive_data, parity_error, framing_error; set receive_flag; errored frames are still delivered.
REQ-026 In COMPLETE with receive_flag=1 and clear_request=0: receive_data/parity/framing unchanged; overrun_error set.
REQ-027 clear_request outside COMPLETE SHALL clear receive_flag, overrun_error, timeout_error next edge; parity/framing bits stay with the data.
REQ-028 Timeout counter (16 bit) SHALL clear on every edge and in IDLE, increment otherwise in DATA/PARITY/STOP; at device_in_timeout -> IDLE, set timeout_error, no data load.
REQ-029 receive_inhibit high SHALL force IDLE and clear counters next edge, without setting any error and without touching receive_flag/data.
REQ-030 Simultaneous timeout and device_clock_edge: edge wins.

Reset
REQ-031 reset_n low SHALL asynchronously set state IDLE, counters and shift register 0, receive_data 8'h00, all flags 0, synchronizer flops 1 (idle bus).
REQ-032 Reset mid-frame SHALL discard the partial frame; reception restarts at next start bit after release.

Structure
REQ-033 Package kfps2kb_pkg SHALL hold the receive state enum and default device_in_timeout constant.
REQ-034 Sub-module kfps2kb_sync_edge (2-flop sync plus falling-edge detect) SHALL be instantiated for device_clock; device_data uses its synced output only.

Verification
REQ-035 Frame 0x1C, parity 0, stop 1 -> receive_data=0x1C, receive_flag=1, all errors 0.
REQ-036 Frame 0x00, parity 0 -> receive_data=0x00, parity_error=1; frame 0xF0, parity 1, stop 0 -> framing_error=1.
REQ-037 Start + 4 data bits, then idle > 4000 clocks -> timeout_error=1, receive_flag=0, IDLE; following 0x5A frame received correctly.
REQ-038 Frames 0x12 then 0x34 without clear -> receive_data=0x12, overrun_error=1; clear_request -> flags 0.
REQ-039 clear_request held high during COMPLETE of 0x34 -> receive_data=0x34, receive_flag=1, overrun_error=0.
REQ-040 receive_inhibit pulsed after D3, and separately reset_n low after D5 -> no flag, no error, next 0xAA received cleanly.

Source files
------------

// File: rtl/kfps2kb_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package kfps2kb_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;
    localparam int unsigned TIMEOUT_W = 16;

    localparam logic [TIMEOUT_W-1:0] DEFAULT_DEVICE_IN_TIMEOUT = 16'd4000;

    typedef enum logic [2:0] {
        RX_IDLE     = 3'd0,
        RX_DATA     = 3'd1,
        RX_PARITY   = 3'd2,
        RX_STOP     = 3'd3,
        RX_COMPLETE = 3'd4
    } rx_state_e;

    // Odd parity: the nine received bits must hold an odd number of ones.
    function automatic logic odd_parity_error(input logic [DATA_W-1:0] data, input logic parity);
        return ~(^data ^ parity);
    endfunction

endpackage

// File: rtl/kfps2kb_sync_edge.sv
// Two-flop synchronizer with falling-edge detect for a raw PS/2 line.
module kfps2kb_sync_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic synced,
    output logic fall_edge_c
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset to 1 so an idle (pulled-up) bus produces no spurious edge.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign synced      = sync_q;
    assign fall_edge_c = prev_q & ~sync_q;

endmodule

// File: rtl/kfps2kb_receive_data.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
module kfps2kb_receive_data
    import kfps2kb_pkg::*;
#(
    parameter logic [15:0] device_in_timeout = DEFAULT_DEVICE_IN_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              device_clock,
    input  logic              device_data,
    input  logic              receive_inhibit,
    input  logic              clear_request,
    output logic [DATA_W-1:0] receive_data,
    output logic              receive_flag,
    output logic              parity_error,
    output logic              framing_error,
    output logic              overrun_error,
    output logic              timeout_error,
    output logic              receiving_flag
);

    logic                 dev_clk_synced;
    logic                 dev_clk_edge_c;
    logic                 data_meta_q;
    logic                 data_sync_q;

    rx_state_e            state_q,   state_n;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_n;
    logic [DATA_W-1:0]    shift_q,   shift_n;
    logic                 parity_q,  parity_n;
    logic                 stop_q,    stop_n;
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_n;
    logic [DATA_W-1:0]    rx_data_n;
    logic                 rx_flag_n, par_err_n, frm_err_n, ovr_err_n, tmo_err_n;

    kfps2kb_sync_edge u_clk_sync (
        .clock       (clock),
        .reset_n     (reset_n),
        .din         (device_clock),
        .synced      (dev_clk_synced),
        .fall_edge_c (dev_clk_edge_c)
    );

    // Data line only needs synchronizing; it is sampled on device_clock edges.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            data_meta_q <= device_data;
            data_sync_q <= data_meta_q;
        end
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= RX_IDLE;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            parity_q       <= 1'b0;
            stop_q         <= 1'b0;
            tmo_cnt_q      <= '0;
            receive_data   <= 8'h00;
            receive_flag   <= 1'b0;
            parity_error   <= 1'b0;
            framing_error  <= 1'b0;
            overrun_error  <= 1'b0;
            timeout_error  <= 1'b0;
            receiving_flag <= 1'b0;
        end else begin
            state_q        <= state_n;
            bit_cnt_q      <= bit_cnt_n;
            shift_q        <= shift_n;
            parity_q       <= parity_n;
            stop_q         <= stop_n;
            tmo_cnt_q      <= tmo_cnt_n;
            receive_data   <= rx_data_n;
            receive_flag   <= rx_flag_n;
            parity_error   <= par_err_n;
            framing_error  <= frm_err_n;
            overrun_error  <= ovr_err_n;
            timeout_error  <= tmo_err_n;
            receiving_flag <= (state_n != RX_IDLE);
        end
    end

    always_comb begin
        state_n   = state_q;
        bit_cnt_n = bit_cnt_q;
        shift_n   = shift_q;
        parity_n  = parity_q;
        stop_n    = stop_q;
        tmo_cnt_n = tmo_cnt_q;
        rx_data_n = receive_data;
        rx_flag_n = receive_flag;
        par_err_n = parity_error;
        frm_err_n = framing_error;
        ovr_err_n = overrun_error;
        tmo_err_n = timeout_error;

        // Consumer acknowledge; a completing frame below may re-set the flag.
        if (clear_request) begin
            rx_flag_n = 1'b0;
            ovr_err_n = 1'b0;
            tmo_err_n = 1'b0;
        end

        if (receive_inhibit) begin
            state_n   = RX_IDLE;
            bit_cnt_n = '0;
            tmo_cnt_n = '0;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    tmo_cnt_n = '0;
                    if (dev_clk_edge_c && !data_sync_q) begin
                        state_n   = RX_DATA;
                        bit_cnt_n = '0;
                    end
                end
                RX_DATA, RX_PARITY, RX_STOP: begin
                    if (dev_clk_edge_c) begin
                        tmo_cnt_n = '0;
                        if (state_q == RX_DATA) begin
                            shift_n   = {data_sync_q, shift_q[DATA_W-1:1]};
                            bit_cnt_n = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) state_n = RX_PARITY;
                        end else if (state_q == RX_PARITY) begin
                            parity_n = data_sync_q;
                            state_n  = RX_STOP;
                        end else begin
                            stop_n  = data_sync_q;
                            state_n = RX_COMPLETE;
                        end
                    end else if (tmo_cnt_q == device_in_timeout) begin
                        state_n   = RX_IDLE;
                        tmo_cnt_n = '0;
                        tmo_err_n = 1'b1;
                    end else begin
                        tmo_cnt_n = tmo_cnt_q + 16'd1;
                    end
                end
                RX_COMPLETE: begin
                    state_n   = RX_IDLE;
                    tmo_cnt_n = '0;
                    if (!receive_flag || clear_request) begin
                        rx_data_n = shift_q;
                        par_err_n = odd_parity_error(shift_q, parity_q);
                        frm_err_n = ~stop_q;
                        rx_flag_n = 1'b1;
                    end else begin
                        ovr_err_n = 1'b1;
                    end
                end
                default: begin
                    state_n   = RX_IDLE;
                    tmo_cnt_n = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kfps2kb_receive_data.sv
// Directed bench for the PS/2 receiver: clean, errored, timed-out, overrun and aborted frames.
module tb_kfps2kb_receive_data;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       device_clock = 1'b1;
    logic       device_data = 1'b1;
    logic       receive_inhibit = 1'b0;
    logic       clear_request = 1'b0;
    logic [7:0] receive_data;
    logic       receive_flag;
    logic       parity_error;
    logic       framing_error;
    logic       overrun_error;
    logic       timeout_error;
    logic       receiving_flag;

    int checks = 0;
    int errors = 0;

    kfps2kb_receive_data dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .device_clock    (device_clock),
        .device_data     (device_data),
        .receive_inhibit (receive_inhibit),
        .clear_request   (clear_request),
        .receive_data    (receive_data),
        .receive_flag    (receive_flag),
        .parity_error    (parity_error),
        .framing_error   (framing_error),
        .overrun_error   (overrun_error),
        .timeout_error   (timeout_error),
        .receiving_flag  (receiving_flag)
    );

    always #5 clock = ~clock;

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One PS/2 bit; optionally pulse clear_request for exactly the COMPLETE cycle
    // that follows this (stop) bit's falling edge.
    task automatic ps2_bit(input logic b, input logic clr_at_complete);
        device_data = b;
        cycles(4);
        device_clock = 1'b0;
        if (clr_at_complete) begin
            cycles(3);
            clear_request = 1'b1;
            cycles(1);
            clear_request = 1'b0;
            cycles(4);
        end else begin
            cycles(8);
        end
        device_clock = 1'b1;
        cycles(8);
    endtask

    task automatic send_bits(input logic [7:0] d, input int nbits);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(d[i], 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input logic clr_at_complete);
        send_bits(d, 8);
        ps2_bit(par, 1'b0);
        ps2_bit(stop, clr_at_complete);
        device_data = 1'b1;
        cycles(4);
    endtask

    task automatic pulse_clear();
        clear_request = 1'b1;
        cycles(2);
        clear_request = 1'b0;
        cycles(2);
    endtask

    task automatic check_flags(input string tag, input logic flag, input logic perr,
                               input logic ferr, input logic oerr, input logic terr);
        check({tag, "_flag"}, 8'(receive_flag), 8'(flag));
        check({tag, "_perr"}, 8'(parity_error), 8'(perr));
        check({tag, "_ferr"}, 8'(framing_error), 8'(ferr));
        check({tag, "_oerr"}, 8'(overrun_error), 8'(oerr));
        check({tag, "_terr"}, 8'(timeout_error), 8'(terr));
    endtask

    initial begin
        cycles(3);
        check("reset_data", receive_data, 8'h00);
        check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_busy", 8'(receiving_flag), 8'h00);
        reset_n = 1'b1;
        cycles(3);

        // Clean frame 0x1C (three ones, parity 0)
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check("f1c_data", receive_data, 8'h1C);
        check_flags("f1c", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("f1c_busy", 8'(receiving_flag), 8'h00);
        pulse_clear();
        check("f1c_clr_flag", 8'(receive_flag), 8'h00);

        // Parity error: 0x00 with parity 0 is even
        send_frame(8'h00, 1'b0, 1'b1, 1'b0);
        check("f00_data", receive_data, 8'h00);
        check_flags("f00", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_clear();
        check("f00_clr_perr_kept", 8'(parity_error), 8'h01);

        // Framing error: 0xF0 parity 1 (odd), stop 0
        send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
        check("ff0_data", receive_data, 8'hF0);
        check_flags("ff0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        pulse_clear();

        // Timeout: start + 4 bits then silence
        send_bits(8'h0F, 4);
        check("tmo_busy_mid", 8'(receiving_flag), 8'h01);
        cycles(3900);
        check("tmo_not_yet", 8'(timeout_error), 8'h00);
        check("tmo_still_busy", 8'(receiving_flag), 8'h01);
        cycles(200);
        check_flags("tmo", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("tmo_idle", 8'(receiving_flag), 8'h00);
        check("tmo_data_kept", receive_data, 8'hF0);
        pulse_clear();
        check("tmo_cleared", 8'(timeout_error), 8'h00);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        check("f5a_data", receive_data, 8'h5A);
        check_flags("f5a", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_clear();

        // Overrun: 0x12 then 0x34 without clear
        send_frame(8'h12, 1'b1, 1'b1, 1'b0);
        send_frame(8'h34, 1'b0, 1'b1, 1'b0);
        check("ovr_data", receive_data, 8'h12);
        check_flags("ovr", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        pulse_clear();
        check_flags("ovr_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Clear coinciding with COMPLETE: second byte is accepted, no overrun
        send_frame(8'h12, 1'b1, 1'b1, 1'b0);
        check("cc_first_flag", 8'(receive_flag), 8'h01);
        send_frame(8'h34, 1'b0, 1'b1, 1'b1);
        check("cc_data", receive_data, 8'h34);
        check_flags("cc", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_clear();

        // Inhibit after D3: frame dropped silently
        send_bits(8'hAA, 4);
        receive_inhibit = 1'b1;
        cycles(4);
        receive_inhibit = 1'b0;
        cycles(4);
        check("inh_idle", 8'(receiving_flag), 8'h00);
        check_flags("inh", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("inh_data_kept", receive_data, 8'h34);

        // Reset after D5: frame dropped, registers back to reset values
        send_bits(8'hAA, 6);
        reset_n = 1'b0;
        cycles(3);
        reset_n = 1'b1;
        cycles(3);
        check("rst_idle", 8'(receiving_flag), 8'h00);
        check("rst_data", receive_data, 8'h00);
        check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Recovery frame 0xAA (four ones, parity 1)
        send_frame(8'hAA, 1'b1, 1'b1, 1'b0);
        check("faa_data", receive_data, 8'hAA);
        check_flags("faa", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
